seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Time-multiplexed seven-segment display driver. Sits directly downstream of the key-select mux stage.
- Consumes a packed vector of hex nibbles plus per-digit blank and decimal-point flags.
- Captures them tear-free at frame boundaries and scans one digit at a time onto a shared segment bus with anode enables.
- Inserts a dead-time cycle at each digit change to suppress ghosting.

Parameters:
- NR_DIGIT, 8: number of digits scanned; must be >= 2.
- CNT_MAX, 4: dwell counter terminal value; each digit is shown for CNT_MAX+1 cycles. Must be >= 1.
- ACTIVE_LOW, 1: 1 inverts both seg and an (common-anode board); 0 gives active-high outputs.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- data  input  4*NR_DIGIT  hex nibbles; digit n = data[4n+3:4n].
- blank  input  NR_DIGIT  1 = digit n is dark.
- dp  input  NR_DIGIT  1 = decimal point lit on digit n.
- load  input  1  request to capture data/blank/dp.
- seg  output  8  {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
- an  output  NR_DIGIT  digit enables, one-hot when lit, polarity per ACTIVE_LOW.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit NR_DIGIT-1 to 0.

Behaviour:
- State:
  - cnt: 0..CNT_MAX.
  - idx: 0..NR_DIGIT-1.
  - pending registers (p_data, p_blank, p_dp) and pend_valid.
  - shadow registers (s_data, s_blank, s_dp).
- Reset (rst=1 at posedge), synchronous, overrides everything:
  - cnt=0, idx=0, pend_valid=0.
  - p_*=0, s_data=0, s_dp=0, s_blank=all ones.
  - seg = all segments off (0xFF if ACTIVE_LOW, else 0x00).
  - an = all off.
  - frame_done=0.
- Counting:
  - cnt increments every cycle. At cnt==CNT_MAX it returns to 0 and idx advances.
  - idx wraps from NR_DIGIT-1 to 0.
  - Frame length = NR_DIGIT*(CNT_MAX+1) cycles.
- Load capture:
  - load=1 copies data/blank/dp into p_* and sets pend_valid. This happens regardless of scan position.
  - A later load before apply overwrites the pending values; last load wins.
- Apply:
  - Occurs on the cycle where cnt==CNT_MAX and idx==NR_DIGIT-1 (wrap).
  - If pend_valid, p_* copies into s_* and pend_valid clears.
  - If load is also 1 on that same cycle, the live inputs go straight to s_* and pend_valid stays 0.
  - Shadow never changes mid-frame.
- frame_done is registered: 1 on the cycle after the wrap edge, otherwise 0.
- Output generation is registered; seg/an at cycle t+1 reflect cnt/idx/s_* at cycle t.
  - If cnt==0 (dead-time) or s_blank[idx]==1: an = all off, seg = all off.
  - Otherwise: an has only bit idx active; seg = hex font of s_data nibble idx, with bit7 = s_dp[idx].
- Hex font, active-high {g..a}:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Polarity: ACTIVE_LOW=1 inverts all 8 seg bits and all an bits after selection.
- Reset mid-frame: next cycle restarts at idx=0, cnt=0, with display dark until a load is applied at the next wrap.
- Widths: idx width = clog2(NR_DIGIT); cnt width = clog2(CNT_MAX+1). Neither may overflow past its terminal value.

Test Plan:
- Reset, then idle 80 cycles with load=0 (defaults NR_DIGIT=8, CNT_MAX=4, ACTIVE_LOW=1) -> seg=0xFF, an=0xFF throughout; frame_done pulses at cycles 40 and 80 after reset release.
- load=1 for one cycle with data=0x76543210, blank=0, dp=0x01 -> no output change until after the next wrap. In the following frame:
  - digit0 shows seg=0x40 ('0' with dp) with an=0xFE for 4 cycles, after one dead cycle with an=0xFF.
  - digit1 shows seg=0xF9 ('1') with an=0xFD.
- Two loads in one frame (data=0x11111111, then 0xFEDCBA98) -> only 0xFEDCBA98 appears. Digit0 shows seg=0x80 ('8', ACTIVE_LOW); digit7 shows seg=0x8E ('F').
- load asserted exactly on the wrap cycle with data=0x0000000A -> applied at that wrap; digit0 shows seg=0x88 ('A') in the immediately following frame; pend_valid=0 afterwards.
- blank=0xAA with data=0x88888888 -> odd digits keep an=0xFF for their whole dwell; even digits show seg=0x80; dead-time cycle present on every digit change.
- rst pulsed mid-frame at idx=5, cnt=2 -> next cycle seg=0xFF, an=0xFF, and the scan restarts at idx=0. Pending load is discarded, and the display stays dark until a new load is applied.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed seven-segment display driver.
//
// Scans NR_DIGIT digits one at a time onto a shared segment bus. Each digit
// is held for CNT_MAX+1 cycles. The first cycle of every dwell is a dark
// dead-time cycle that suppresses ghosting. New digit contents are captured
// into a pending buffer by load. They reach the displayed shadow copy only
// at the frame wrap, so a frame never shows a mix of old and new contents.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst        synchronous active-high reset
//   data       packed hex nibbles, digit n = data[4n+3:4n]
//   blank      per-digit blank flags (1 = dark)
//   dp         per-digit decimal point flags (1 = lit)
//   load       capture request for data/blank/dp
//   seg        {dp,g,f,e,d,c,b,a}, inverted when ACTIVE_LOW != 0
//   an         digit enables, one-hot when lit, inverted when ACTIVE_LOW != 0
//   frame_done one-cycle pulse after the scan wraps from the last digit to 0
module seg_scan #(
    parameter int NR_DIGIT   = 8,
    parameter int CNT_MAX    = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NR_DIGIT-1:0]   data,
    input  logic [NR_DIGIT-1:0]     blank,
    input  logic [NR_DIGIT-1:0]     dp,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NR_DIGIT-1:0]     an,
    output logic                    frame_done
);

    localparam int IW = $clog2(NR_DIGIT);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
    localparam logic [IW-1:0] IDX_TOP = IW'(NR_DIGIT - 1);
    localparam logic          POL     = (ACTIVE_LOW != 0);

    // Active-high {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;

    logic [4*NR_DIGIT-1:0]   p_data;
    logic [NR_DIGIT-1:0]     p_blank;
    logic [NR_DIGIT-1:0]     p_dp;
    logic                    pend_valid;

    logic [4*NR_DIGIT-1:0]   s_data;
    logic [NR_DIGIT-1:0]     s_blank;
    logic [NR_DIGIT-1:0]     s_dp;

    logic                    wrap;
    logic                    lit;
    logic [3:0]              nib;
    logic [7:0]              seg_raw;
    logic [NR_DIGIT-1:0]     an_raw;

    always_comb begin
        wrap    = (cnt == CNT_TOP) && (idx == IDX_TOP);
        nib     = s_data[{idx, 2'b00} +: 4];
        // cnt == 0 is the dead-time slot at the start of every dwell.
        lit     = (cnt != '0) && !s_blank[idx];
        seg_raw = 8'h00;
        an_raw  = '0;
        if (lit) begin
            seg_raw = {s_dp[idx], hex_font(nib)};
            an_raw  = {{(NR_DIGIT-1){1'b0}}, 1'b1} << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            pend_valid <= 1'b0;
            p_data     <= '0;
            p_blank    <= '0;
            p_dp       <= '0;
            s_data     <= '0;
            s_blank    <= '1;
            s_dp       <= '0;
            seg        <= {8{POL}};
            an         <= {NR_DIGIT{POL}};
            frame_done <= 1'b0;
        end else begin
            // scan position
            if (cnt == CNT_TOP) begin
                cnt <= '0;
                idx <= (idx == IDX_TOP) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // pending capture; last load before the wrap wins
            if (load) begin
                p_data  <= data;
                p_blank <= blank;
                p_dp    <= dp;
            end

            // shadow update only at the frame wrap; a load on the wrap cycle
            // bypasses the pending buffer so it is shown in the very next frame
            if (wrap) begin
                pend_valid <= 1'b0;
                if (load) begin
                    s_data  <= data;
                    s_blank <= blank;
                    s_dp    <= dp;
                end else if (pend_valid) begin
                    s_data  <= p_data;
                    s_blank <= p_blank;
                    s_dp    <= p_dp;
                end
            end else if (load) begin
                pend_valid <= 1'b1;
            end

            // registered outputs, polarity applied after selection
            frame_done <= wrap;
            seg        <= seg_raw ^ {8{POL}};
            an         <= an_raw ^ {NR_DIGIT{POL}};
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with default parameters (8 digits, CNT_MAX=4,
// active-low outputs). Expected seg/an/frame_done values for each output
// cycle are queued when a step is set up and are compared as the cycles occur.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic        load;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        frame_done;

    seg_scan #(.NR_DIGIT(8), .CNT_MAX(4), .ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .blank      (blank),
        .dp         (dp),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         step;
        logic [7:0] seg;
        logic [7:0] an;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
            4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
            4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
            4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Expected outputs for a frame whose first scan cycle (idx 0, cnt 0) is f.
    // Output at f+1+k shows scan slot k: slot%5==0 is dead time.
    task automatic push_frame(input int f, input logic [31:0] d, input logic [7:0] b,
                              input logic [7:0] p, input int n, input int step);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            int   dg;
            int   ph;
            dg     = k / 5;
            ph     = k % 5;
            e.cyc  = f + 1 + k;
            e.step = step;
            e.fd   = (k == 39);
            if (ph == 0 || b[dg]) begin
                e.seg = 8'hFF;
                e.an  = 8'hFF;
            end else begin
                e.seg = ~{p[dg], font(d[dg*4 +: 4])};
                e.an  = ~(8'h01 << dg);
            end
            q.push_back(e);
        end
    endtask

    task automatic push_off(input int c, input int step);
        exp_t e;
        e.cyc  = c;
        e.step = step;
        e.seg  = 8'hFF;
        e.an   = 8'hFF;
        e.fd   = 1'b0;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
        data  = d;
        blank = b;
        dp    = p;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // scoreboard checker, sampling on the falling edge
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            errors++;
            $error("FAIL step%0d missed cyc %0d now %0d", q[0].step, q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            assert (seg === e.seg) else begin
                errors++;
                $error("FAIL step%0d seg cyc %0d got %h exp %h", e.step, cyc, seg, e.seg);
            end
            checks++;
            assert (an === e.an) else begin
                errors++;
                $error("FAIL step%0d an cyc %0d got %h exp %h", e.step, cyc, an, e.an);
            end
            checks++;
            assert (frame_done === e.fd) else begin
                errors++;
                $error("FAIL step%0d frame_done cyc %0d got %b exp %b", e.step, cyc, frame_done, e.fd);
            end
        end
    end

    int r;
    int r2;
    int guard;

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        data  = '0;
        blank = '0;
        dp    = '0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        r   = cyc;

        // step 1: reset state, then two idle dark frames
        push_off(r, 1);
        push_frame(r,      32'h0, 8'hFF, 8'h00, 40, 1);
        push_frame(r + 40, 32'h0, 8'hFF, 8'h00, 40, 1);
        wait_until(r + 80);

        // step 2: single load, visible only from the following frame
        push_frame(r + 80,  32'h0,        8'hFF, 8'h00, 40, 2);
        push_frame(r + 120, 32'h76543210, 8'h00, 8'h01, 40, 2);
        wait_until(r + 83);
        do_load(32'h76543210, 8'h00, 8'h01);

        // step 3: two loads in one frame, last wins
        wait_until(r + 160);
        push_frame(r + 160, 32'h76543210, 8'h00, 8'h01, 40, 3);
        push_frame(r + 200, 32'hFEDCBA98, 8'h00, 8'h00, 40, 3);
        wait_until(r + 162);
        do_load(32'h11111111, 8'h00, 8'h00);
        wait_until(r + 180);
        do_load(32'hFEDCBA98, 8'h00, 8'h00);

        // step 4: load on the wrap cycle bypasses a pending load
        wait_until(r + 240);
        push_frame(r + 240, 32'hFEDCBA98, 8'h00, 8'h00, 40, 4);
        push_frame(r + 280, 32'h0000000A, 8'h00, 8'h00, 40, 4);
        push_frame(r + 320, 32'h0000000A, 8'h00, 8'h00, 40, 4);
        wait_until(r + 250);
        do_load(32'h55555555, 8'h00, 8'hFF);
        wait_until(r + 279);
        do_load(32'h0000000A, 8'h00, 8'h00);

        // step 5: odd digits blanked
        wait_until(r + 320);
        push_frame(r + 360, 32'h88888888, 8'hAA, 8'h00, 40, 5);
        wait_until(r + 325);
        do_load(32'h88888888, 8'hAA, 8'h00);
        blank = 8'h00;

        // step 6: reset at idx 5 cnt 2 discards a pending load
        wait_until(r + 400);
        push_frame(r + 400, 32'h88888888, 8'hAA, 8'h00, 27, 6);
        wait_until(r + 405);
        do_load(32'h12121212, 8'h00, 8'h00);
        wait_until(r + 427);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r2  = cyc;
        push_off(r2, 6);
        push_frame(r2,      32'h0,        8'hFF, 8'h00, 40, 6);
        push_frame(r2 + 40, 32'h0,        8'hFF, 8'h00, 40, 6);
        push_frame(r2 + 80, 32'h12345678, 8'h00, 8'h80, 40, 6);
        wait_until(r2 + 50);
        do_load(32'h12345678, 8'h00, 8'h80);

        guard = 0;
        while (q.size() > 0 && guard < 300) begin
            tick();
            guard++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain timeout left %0d exp 0", q.size());
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
